// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS pipeline stages
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR = 32'd4;
endpackage

// File: rtl/adder.sv
// adder: plain modulo-2^W adder
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch, PC select and IF/ID pipeline register
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid,
  output logic            misalign_err
);
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, pc_plus4;
  logic valid_q, valid_d, mis_q, mis_d, hold, adv;
  adder #(.W(XLEN)) u_pc_adder (.a(pc_q), .b(PC_INCR), .y(pc_plus4));
  // redirect beats stall; anything that is neither hold nor advance is a bubble
  always_comb begin
    hold = !redirect && stall;
    adv = !redirect && !stall && imem_ready;
    pc_d = redirect ? {redirect_target[XLEN-1:2], 2'b00} : adv ? pc_plus4 : pc_q;
    instr_d = hold ? instr_q : adv ? imem_rdata : NOP_INSTR;
    pc4_d = hold ? pc4_q : adv ? pc_plus4 : '0;
    valid_d = hold ? valid_q : adv;
    mis_d = redirect && |redirect_target[1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q <= '0;
      valid_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      mis_q <= mis_d;
    end
  end
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid = valid_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven vectors with an expected-value queue for if_stage
module tb_if_stage;
  import mips_pkg::*;
  typedef struct {
    logic rst, stall, redirect, ready;
    logic [31:0] target, rdata, e_pc, e_instr, e_p4;
    logic e_valid, e_mis;
  } vec_t;
  typedef struct {
    logic [31:0] pc, instr, p4;
    logic valid, mis;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0;
  logic [31:0] redirect_target = '0, imem_rdata = '0;
  logic [31:0] imem_addr, pc, if_id_instr, if_id_pc_plus4;
  logic if_id_valid, misalign_err;
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  vec_t tbl[16];
  always #5 clk = ~clk;
  if_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err)
  );
  function automatic vec_t mk(input logic r, s, d, y, input logic [31:0] t, rd, epc, ein, ep4,
                              input logic ev, em);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = d; v.ready = y; v.target = t; v.rdata = rd;
    v.e_pc = epc; v.e_instr = ein; v.e_p4 = ep4; v.e_valid = ev; v.e_mis = em;
    return v;
  endfunction
  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; redirect = v.redirect; imem_ready = v.ready;
    redirect_target = v.target; imem_rdata = v.rdata;
    e.pc = v.e_pc; e.instr = v.e_instr; e.p4 = v.e_p4; e.valid = v.e_valid; e.mis = v.e_mis;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("pc", idx, pc, e.pc);
    check("imem_addr", idx, imem_addr, e.pc);
    check("if_id_instr", idx, if_id_instr, e.instr);
    check("if_id_pc_plus4", idx, if_id_pc_plus4, e.p4);
    check("if_id_valid", idx, {31'b0, if_id_valid}, {31'b0, e.valid});
    check("misalign_err", idx, {31'b0, misalign_err}, {31'b0, e.mis});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    //                 rst   stall redir ready target        rdata         pc            instr         pc+4          valid mis
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h2008_0005, 32'h4,       32'h2008_0005, 32'h4,       1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h2009_0003, 32'h8,       32'h2009_0003, 32'h8,       1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0109_5020, 32'h8,       32'h2009_0003, 32'h8,       1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0109_5020, 32'h8,       32'h2009_0003, 32'h8,       1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0109_5020, 32'hC,       32'h0109_5020, 32'hC,       1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h40,        32'hDEAD_BEEF, 32'h40,      32'h0,        32'h0,        1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h8C01_0000, 32'h44,      32'h8C01_0000, 32'h44,      1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h102,       32'h5555_5555, 32'h100,     32'h0,        32'h0,        1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hAAAA_0001, 32'h104,     32'hAAAA_0001, 32'h104,     1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h10,        32'h0,        32'h10,       32'h0,        32'h0,        1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h7777_7777, 32'h10,      32'h0,        32'h0,        1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h7777_7777, 32'h10,      32'h0,        32'h0,        1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h1234_5678, 32'h14,      32'h1234_5678, 32'h14,      1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hCAFE_BABE, 32'h0,       32'hCAFE_BABE, 32'h0,       1'b1, 1'b0);
    for (int i = 0; i < 16; i++) apply(i, tbl[i]);
    // reset arriving mid-stall, then the first fetch must come from RESET_PC
    apply(16, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 32'h4, 32'h1111_1111, 32'h4, 1'b1, 1'b0));
    apply(17, mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h9999_9999, 32'h4, 32'h1111_1111, 32'h4, 1'b1, 1'b0));
    apply(18, mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h9999_9999, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    apply(19, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2222_2222, 32'h4, 32'h2222_2222, 32'h4, 1'b1, 1'b0));
    // reset beats a simultaneous misaligned redirect
    apply(20, mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h203, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    apply(21, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3333_3333, 32'h4, 32'h3333_3333, 32'h4, 1'b1, 1'b0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
